// File: rtl/clk_div_bank_if.sv
// Control and output bundle for clk_div_bank: per-channel enable/load/ratio in,
// divided clocks, tick strobes and pending flags out.
interface clk_div_bank_if #(
   parameter int NCH   = 2,
   parameter int CNT_W = 16
);
   logic [NCH-1:0]       en;
   logic [NCH-1:0]       load;
   logic [NCH*CNT_W-1:0] div_in;
   logic                 sync;
   logic [NCH-1:0]       clk_out;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       pend;

   // load is a one-cycle strobe with no ready: the ratio on div_in is taken on
   // every sys_clk edge where load[i] is sampled high, and the newest one wins.
   modport master (output en, load, div_in, sync, input clk_out, tick, pend);
   modport slave  (input en, load, div_in, sync, output clk_out, tick, pend);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NCH integer clock dividers with glitch-free runtime ratio changes.
// Define CLK_DIV_BANK_PHASE_ALIGN_EN to let ctl.sync force a common period boundary.
module clk_div_bank #(
   parameter int NCH     = 2,
   parameter int CNT_W   = 16,
   parameter int RST_DIV = 100
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   clk_div_bank_if.slave ctl
);
   localparam logic [CNT_W-1:0] RST_N_ACT = CNT_W'(RST_DIV);
   localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(RST_DIV - 1);
   localparam logic [CNT_W-1:0] MIN_DIV   = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic sync_c;
`ifdef CLK_DIV_BANK_PHASE_ALIGN_EN
   assign sync_c = ctl.sync;
`else
   logic unused_sync;
   assign unused_sync = ctl.sync;
   assign sync_c      = 1'b0;
`endif

   logic [NCH-1:0] clk_q;
   logic [NCH-1:0] tick_q;
   logic [NCH-1:0] pend_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_r, n_act_r, n_pend_r;
      logic             pend_r, clk_r, tick_r;
      logic [CNT_W-1:0] raw_c, req_c, next_n_c, cnt_inc_c;
      logic [CNT_W:0]   half_c;
      logic             boundary_c;

      always_comb begin
         raw_c      = ctl.div_in[g*CNT_W +: CNT_W];
         req_c      = (raw_c < MIN_DIV) ? MIN_DIV : raw_c;
         // Ratio for a period starting now: a same-edge load beats an older pending one.
         next_n_c   = ctl.load[g] ? req_c : (pend_r ? n_pend_r : n_act_r);
         boundary_c = (cnt_r == n_act_r - ONE);
         half_c     = ({1'b0, n_act_r} + (CNT_W+1)'(1)) >> 1;
         cnt_inc_c  = cnt_r + ONE;
      end

      always_ff @(posedge sys_clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_r    <= RST_CNT;
            n_act_r  <= RST_N_ACT;
            n_pend_r <= RST_N_ACT;
            pend_r   <= 1'b0;
            clk_r    <= 1'b0;
            tick_r   <= 1'b0;
         end else if (!ctl.en[g]) begin
            // Parked one cycle before a boundary so the first enabled edge starts a period.
            n_act_r <= next_n_c;
            cnt_r   <= next_n_c - ONE;
            pend_r  <= 1'b0;
            clk_r   <= 1'b0;
            tick_r  <= 1'b0;
         end else if (sync_c || boundary_c) begin
            n_act_r <= next_n_c;
            cnt_r   <= '0;
            pend_r  <= 1'b0;
            clk_r   <= 1'b1;
            tick_r  <= 1'b1;
         end else begin
            cnt_r  <= cnt_inc_c;
            clk_r  <= ({1'b0, cnt_inc_c} < half_c);
            tick_r <= 1'b0;
            if (ctl.load[g]) begin
               n_pend_r <= req_c;
               pend_r   <= 1'b1;
            end
         end
      end

      assign clk_q[g]  = clk_r;
      assign tick_q[g] = tick_r;
      assign pend_q[g] = pend_r;
   end

   assign ctl.clk_out = clk_q;
   assign ctl.tick    = tick_q;
   assign ctl.pend    = pend_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random traffic,
// all cycles compared against a period/phase reference model.
module tb_clk_div_bank;
   localparam int NCH     = 2;
   localparam int CNT_W   = 16;
   localparam int RST_DIV = 100;
   localparam int W       = 3 * NCH;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;

   clk_div_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

   clk_div_bank #(.NCH(NCH), .CNT_W(CNT_W), .RST_DIV(RST_DIV)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .ctl     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: each channel is either idle or somewhere inside a period of m_n cycles.
   int m_n    [NCH];
   int m_pn   [NCH];
   int m_ph   [NCH];
   bit m_run  [NCH];
   bit m_pend [NCH];
   logic [W-1:0] exp_q[$];

   task automatic model_step();
      bit sync_v;
`ifdef CLK_DIV_BANK_PHASE_ALIGN_EN
      sync_v = bus.sync;
`else
      sync_v = 1'b0;
`endif
      for (int ch = 0; ch < NCH; ch++) begin
         int req;
         bit ld;
         req = int'(bus.div_in[ch*CNT_W +: CNT_W]);
         if (req < 2) req = 2;
         ld = bus.load[ch];
         if (!rst_n) begin
            m_n[ch] = RST_DIV; m_run[ch] = 0; m_pend[ch] = 0; m_ph[ch] = 0;
         end else if (!bus.en[ch]) begin
            if (ld) m_n[ch] = req;
            else if (m_pend[ch]) m_n[ch] = m_pn[ch];
            m_pend[ch] = 0; m_run[ch] = 0;
         end else if (sync_v || !m_run[ch] || m_ph[ch] == m_n[ch] - 1) begin
            if (ld) m_n[ch] = req;
            else if (m_pend[ch]) m_n[ch] = m_pn[ch];
            m_pend[ch] = 0; m_run[ch] = 1; m_ph[ch] = 0;
         end else begin
            m_ph[ch] = m_ph[ch] + 1;
            if (ld) begin m_pn[ch] = req; m_pend[ch] = 1; end
         end
      end
   endtask

   // Scoreboard: predict at the edge, compare 1 time unit later.
   always @(posedge sys_clk) begin : sb
      logic [NCH-1:0] e_clk, e_tick, e_pend;
      logic [W-1:0]   exp_v, obs_v;
      model_step();
      for (int ch = 0; ch < NCH; ch++) begin
         e_clk[ch]  = m_run[ch] && (m_ph[ch] < (m_n[ch] + 1) / 2);
         e_tick[ch] = m_run[ch] && (m_ph[ch] == 0);
         e_pend[ch] = m_pend[ch];
      end
      exp_q.push_back({e_clk, e_tick, e_pend});
      #1;
      obs_v = {bus.clk_out, bus.tick, bus.pend};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs_v !== exp_v)
         $display("FAIL model t=%0t clk/tick/pend got=%b expected=%b", $time, obs_v, exp_v);
      else
         n_pass++;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Returns the number of edges until tick[ch], or -1 if the budget runs out.
   task automatic wait_tick(input int ch, input int limit, output int n);
      n = 0;
      while (1) begin
         cyc(1);
         n++;
         if (bus.tick[ch]) return;
         if (n >= limit) begin n = -1; return; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.en = '0; bus.load = '0; bus.div_in = '0; bus.sync = 1'b0;
      cyc(3);
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.pend} !== '0)
         $display("FAIL reset_outputs got=%b expected=0", {bus.clk_out, bus.tick, bus.pend});
      else n_pass++;
   endtask

   task automatic test_reset_release();
      int hi0, tk0;
      hi0 = 0; tk0 = 0;
      rst_n = 1'b1; bus.en = '1;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         if (i == 0) begin
            n_checks++;
            if ({bus.clk_out, bus.tick} !== {2'b11, 2'b11})
               $display("FAIL first_enabled_edge got=%b expected=1111", {bus.clk_out, bus.tick});
            else n_pass++;
         end
         hi0 += int'(bus.clk_out[0]);
         tk0 += int'(bus.tick[0]);
      end
      n_checks++;
      if (hi0 != 100) $display("FAIL rst_div_high got=%0d expected=100", hi0); else n_pass++;
      n_checks++;
      if (tk0 != 2) $display("FAIL rst_div_ticks got=%0d expected=2", tk0); else n_pass++;
   endtask

   task automatic test_load_mid();
      int n;
      logic [9:0] s_clk, s_tick;
      cyc(30);
      bus.div_in[0 +: CNT_W] = CNT_W'(5); bus.load = 2'b01;
      cyc(1);
      bus.load = '0;
      n_checks++;
      if (bus.pend[0] !== 1'b1) $display("FAIL load_mid_pend got=%b expected=1", bus.pend[0]); else n_pass++;
      wait_tick(0, 200, n);
      n_checks++;
      if (n != 70) $display("FAIL old_period_intact got=%0d expected=70", n); else n_pass++;
      n_checks++;
      if (bus.pend[0] !== 1'b0) $display("FAIL pend_cleared got=%b expected=0", bus.pend[0]); else n_pass++;
      s_clk = '0; s_tick = '0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc(1);
         s_clk  = {s_clk[8:0], bus.clk_out[0]};
         s_tick = {s_tick[8:0], bus.tick[0]};
      end
      n_checks++;
      if ({s_clk, s_tick} !== {10'b1110011100, 10'b1000010000})
         $display("FAIL n5_wave got=%b/%b expected=1110011100/1000010000", s_clk, s_tick);
      else n_pass++;
   endtask

   task automatic test_clamp();
      int n;
      logic [7:0] s0, s1, t0, t1;
      bus.div_in = {CNT_W'(1), CNT_W'(0)}; bus.load = 2'b11;
      cyc(1);
      bus.load = '0;
      n_checks++;
      if (bus.pend !== 2'b10) $display("FAIL clamp_pend got=%b expected=10", bus.pend); else n_pass++;
      wait_tick(1, 200, n);
      n_checks++;
      if (n != 90) $display("FAIL clamp_wait got=%0d expected=90", n); else n_pass++;
      s0 = '0; s1 = '0; t0 = '0; t1 = '0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc(1);
         s0 = {s0[6:0], bus.clk_out[0]}; s1 = {s1[6:0], bus.clk_out[1]};
         t0 = {t0[6:0], bus.tick[0]};    t1 = {t1[6:0], bus.tick[1]};
      end
      n_checks++;
      if ({s0, s1, t0, t1} !== {4{8'b10101010}})
         $display("FAIL clamp_wave got=%b %b %b %b expected=10101010 x4", s0, s1, t0, t1);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n;
      bus.div_in[0 +: CNT_W] = CNT_W'(20); bus.load = 2'b01;
      cyc(1);
      bus.load = '0;
      n_checks++;
      if ({bus.tick[0], bus.pend[0]} !== 2'b10)
         $display("FAIL boundary_load_20 got=%b expected=10", {bus.tick[0], bus.pend[0]});
      else n_pass++;
      cyc(3);
      bus.div_in[0 +: CNT_W] = CNT_W'(7); bus.load = 2'b01;
      cyc(1);
      bus.div_in[0 +: CNT_W] = CNT_W'(9);
      cyc(1);
      bus.load = '0;
      n_checks++;
      if (bus.pend[0] !== 1'b1) $display("FAIL double_load_pend got=%b expected=1", bus.pend[0]); else n_pass++;
      wait_tick(0, 100, n);
      n_checks++;
      if (n != 15) $display("FAIL n20_finish got=%0d expected=15", n); else n_pass++;
      wait_tick(0, 100, n);
      n_checks++;
      if (n != 9) $display("FAIL last_load_wins got=%0d expected=9", n); else n_pass++;
      cyc(8);
      bus.div_in[0 +: CNT_W] = CNT_W'(4); bus.load = 2'b01;
      cyc(1);
      bus.load = '0;
      n_checks++;
      if ({bus.tick[0], bus.pend[0]} !== 2'b10)
         $display("FAIL boundary_load_4 got=%b expected=10", {bus.tick[0], bus.pend[0]});
      else n_pass++;
      wait_tick(0, 100, n);
      n_checks++;
      if (n != 4) $display("FAIL boundary_load_period got=%0d expected=4", n); else n_pass++;
   endtask

   task automatic test_enable_drop();
      int hi, tk;
      cyc(1);
      bus.en = 2'b10;
      cyc(1);
      n_checks++;
      if ({bus.clk_out[0], bus.tick[0]} !== 2'b00)
         $display("FAIL disabled_out got=%b expected=00", {bus.clk_out[0], bus.tick[0]});
      else n_pass++;
      bus.div_in[0 +: CNT_W] = CNT_W'(12); bus.load = 2'b01;
      cyc(1);
      bus.load = '0;
      n_checks++;
      if (bus.pend[0] !== 1'b0) $display("FAIL disabled_load_pend got=%b expected=0", bus.pend[0]); else n_pass++;
      hi = 0;
      for (int i = 0; i < 8; i++) begin cyc(1); hi += int'(bus.clk_out[0]); end
      n_checks++;
      if (hi != 0) $display("FAIL disabled_high got=%0d expected=0", hi); else n_pass++;
      bus.en = 2'b11;
      cyc(1);
      n_checks++;
      if ({bus.clk_out[0], bus.tick[0]} !== 2'b11)
         $display("FAIL reenable_edge got=%b expected=11", {bus.clk_out[0], bus.tick[0]});
      else n_pass++;
      hi = 0; tk = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         hi += int'(bus.clk_out[0]);
         tk += int'(bus.tick[0]);
      end
      n_checks++;
      if (hi != 6 || tk != 1 || bus.tick[0] !== 1'b1)
         $display("FAIL reenable_period high=%0d ticks=%0d last=%b expected=6 1 1", hi, tk, bus.tick[0]);
      else n_pass++;
   endtask

   task automatic test_sync();
      int n;
      bus.div_in = {CNT_W'(100), CNT_W'(10)}; bus.load = 2'b11;
      cyc(1);
      bus.load = '0;
      wait_tick(1, 10, n);
      cyc(37);
      bus.sync = 1'b1;
      cyc(1);
      bus.sync = 1'b0;
`ifdef CLK_DIV_BANK_PHASE_ALIGN_EN
      n_checks++;
      if (bus.tick !== 2'b11) $display("FAIL sync_edge_tick got=%b expected=11", bus.tick); else n_pass++;
      n = 0;
      for (int i = 0; i < 200; i++) begin cyc(1); if (bus.tick === 2'b11) n++; end
      n_checks++;
      if (n != 2) $display("FAIL sync_coincide got=%0d expected=2", n); else n_pass++;
`else
      n_checks++;
      if (bus.tick !== 2'b00) $display("FAIL sync_ignored got=%b expected=00", bus.tick); else n_pass++;
`endif
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            bus.en[ch]   = ($urandom_range(0, 19) != 0);
            bus.load[ch] = ($urandom_range(0, 6) == 0);
            bus.div_in[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
         end
         bus.sync = ($urandom_range(0, 40) == 0);
         cyc(1);
      end
      bus.load = '0; bus.sync = 1'b0; bus.en = '1;
   endtask

   task automatic test_reset_mid();
      int n;
      cyc(2);
      bus.div_in = {CNT_W'(50), CNT_W'(50)}; bus.load = 2'b11;
      cyc(1);
      bus.load = '0;
      cyc(1);
      bus.div_in = {CNT_W'(30), CNT_W'(30)}; bus.load = 2'b11;
      cyc(1);
      bus.load = '0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.clk_out, bus.tick, bus.pend} !== '0)
         $display("FAIL async_reset got=%b expected=0", {bus.clk_out, bus.tick, bus.pend});
      else n_pass++;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      n_checks++;
      if (bus.tick !== 2'b11) $display("FAIL post_reset_tick got=%b expected=11", bus.tick); else n_pass++;
      wait_tick(0, 200, n);
      n_checks++;
      if (n != RST_DIV) $display("FAIL post_reset_period got=%0d expected=%0d", n, RST_DIV); else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_release();
      test_load_mid();
      test_clamp();
      test_back_to_back();
      test_enable_drop();
      test_sync();
      test_random();
      test_reset_mid();
      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent integer clock dividers running from the system clock. It replaces ad-hoc reference dividers and LED blink counters. Each channel has:
- a runtime-programmable divide ratio, applied glitch-free at period boundaries;
- a near-50 % duty registered clock output;
- a single-cycle tick strobe.

Typical use: generating the PLL reference clock and slow status/visualisation clocks.

## Interface
Parameters:
- NCH, 2, number of divider channels (1..8)
- CNT_W, 16, divide-ratio and counter width in bits
- RST_DIV, 100, divide ratio loaded into every channel at reset (must satisfy 2 ≤ RST_DIV < 2^CNT_W)

Ports:
- sys_clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  NCH  per-channel run enable
- load  in  NCH  per-channel strobe that captures div_in
- div_in  in  NCH*CNT_W  requested ratio N; channel i uses bits [i*CNT_W +: CNT_W]
- sync  in  1  phase-align strobe (active only with the macro below)
- clk_out  out  NCH  divided clocks, registered
- tick  out  NCH  one-cycle pulse coinciding with each clk_out rising edge
- pend  out  NCH  a loaded ratio is waiting for the next period boundary

## Operation
- Per-channel state:
  - cnt[CNT_W]
  - N_act (active ratio)
  - N_pend (pending ratio)
  - pend
  - clk_out
  - tick
- Ratio clamp: any N < 2 (0 or 1) written via load is stored as 2.
- Derived threshold H = ceil(N_act/2), i.e. (N_act+1)>>1, computed at CNT_W+1 bits with no overflow. clk_out is high for H cycles and low for N_act−H cycles.
- Disabled (en[i]=0):
  - cnt ← N_act−1, clk_out ← 0, tick ← 0.
  - A pending ratio is applied in the same edge: N_act ← N_pend, cnt ← N_pend−1, pend ← 0.
  - A load while disabled is applied immediately and pend stays 0.
- Enabled (en[i]=1), each edge:
  - cnt_next = (cnt == N_act−1) ? 0 : cnt+1.
  - clk_out ← (cnt_next < H).
  - tick ← (cnt_next == 0).
- Period boundary: the edge where cnt == N_act−1 and en=1.
  - If pend is set: N_act ← N_pend and pend ← 0.
  - The new period uses the new N, and H is recomputed from it.
- Load handling:
  - load[i] mid-period: N_pend ← clamp(div_in), pend ← 1. Repeated loads overwrite the pending value; last one wins.
  - Load on the boundary edge: the loaded value becomes N_act for the period starting on that edge, and pend stays 0.
- Because the first edge after en rises is a boundary, it produces clk_out=1 and tick=1.
- Priority, highest first: reset > en=0 > sync > boundary/load > count.
- Reset mid-operation: all channels return to reset values immediately; no pending ratio survives.

## Timing
- Reset values:
  - cnt = RST_DIV−1, N_act = RST_DIV
  - pend = 0, clk_out = 0, tick = 0
- Enable latency: clk_out and tick rise on the first sys_clk edge where en=1 is sampled.
- Period: exactly N_act sys_clk cycles, measured rising edge to rising edge, with no runt pulses across a reconfiguration.
- Load-to-effect: a load takes effect at the next boundary edge, at most N_act cycles later. pend is visible the cycle after load.
- Outputs are purely registered; there are no combinational paths from inputs to outputs.
- Channels are independent apart from the shared sync.

## Configuration
- Macro: CLK_DIV_BANK_PHASE_ALIGN_EN.
- Defined: a sync pulse on an edge forces every enabled channel to a boundary on that edge:
  - pending ratio applied;
  - cnt ← 0, clk_out ← 1, tick ← 1.
  - Disabled channels ignore sync.
- Undefined: the sync port exists but is ignored. No sync logic is synthesised, and channels free-run from their own enable edge.

## Test plan
- Reset release with en=1, RST_DIV=100 → clk_out high 50 / low 50 cycles, tick every 100 cycles, first tick on the first enabled edge.
- load N=5 on channel 0 mid-period → pend=1 until the boundary. Old period completes intact, then high 3 / low 2, period 5, pend=0.
- load N=0 and N=1 → both behave as N=2: clk_out toggles every cycle, tick every 2 cycles.
- Two loads (7 then 9) within one period → the next period uses 9. A load asserted on the boundary edge applies immediately with pend staying 0.
- Drop en for 10 cycles mid-high, then reassert → clk_out=0 while disabled. Rising edge and tick occur on the first enabled edge, with a full N-cycle period following.
- With CLK_DIV_BANK_PHASE_ALIGN_EN: channels at N=100 and N=10 with offset phases, pulse sync → both ticks coincide on the sync edge, and ticks coincide every 100 cycles thereafter. Without the macro, sync has no effect.
